regex_prog_matcher: RTL and testbench
=====================================

Name: regex_prog_matcher

Overview:
- Programmable, anchored sequence-regex matcher. Successor to the fixed-pattern 2-bit-symbol regex FSM.
- Pattern is up to MAX_ELEMS elements. Each element is a literal symbol with an optional "+" (one-or-more) flag, e.g. AB+CA+BD.
- Consumes a stream of symbols with a valid qualifier and a last-symbol marker. Reports match/no-match per string, keeps a saturating match counter, and accepts back-to-back strings without reset.

Parameters:
- SYM_W, 2, symbol width in bits (2 gives A=0, B=1, C=2, D=3).
- MAX_ELEMS, 8, maximum pattern elements.
- CNT_W, 8, match_count width.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- res_n  in  1  reset, asynchronous, active-low.
- cfg_we  in  1  write pattern element.
- cfg_addr  in  clog2(MAX_ELEMS)  element index for cfg_we.
- cfg_sym  in  SYM_W  element literal.
- cfg_rep  in  1  1 = element is "+" (one-or-more), 0 = exactly one.
- cfg_len_we  in  1  write pattern length.
- cfg_len  in  clog2(MAX_ELEMS+1)  number of active elements.
- symbol_valid  in  1  symbol_in is consumed this edge.
- symbol_in  in  SYM_W  input symbol.
- last_symbol  in  1  qualifies the consumed symbol as the final one of the string.
- busy  out  1  string in progress (RUN state).
- result  out  1  1 = last completed string matched the whole pattern.
- done  out  1  result is valid.
- match_count  out  CNT_W  count of matched strings, saturating.

Behaviour:
- Reset (res_n=0, async):
  - State=IDLE; busy=0, result=0, done=0, match_count=0.
  - All element registers = {sym 0, rep 0}; length register = 0.
- State machine, states IDLE / RUN / DONE:
  - IDLE or DONE, valid & !last: go to RUN; consume symbol from the start set; done=0, result=0.
  - IDLE or DONE, valid & last: one-symbol string. Evaluate and stay or go to DONE. done=1 and result are updated at the same edge.
  - RUN, valid & !last: consume symbol.
  - RUN, valid & last: consume symbol, go to DONE; done=1, result=match at that edge.
  - valid=0 in any state: no state change (stall). last_symbol without valid is ignored.
  - done and result hold in DONE until the next valid symbol or reset.
- Matching, as an NFA active-set vector act[0..MAX_ELEMS]:
  - act[0]=1 only at string start.
  - Per consumed symbol s: nxt[i+1] = (act[i] & s==sym[i]) | (act[i+1] & rep[i] & s==sym[i]), for i < len; nxt[0]=0; bits above len are 0.
  - Match = nxt[len] on the last symbol (anchored at both ends).
- Latency: the result of a string is visible immediately after the edge that consumes its last symbol.
- len=0: every string gives result=0.
- Writing cfg_len > MAX_ELEMS clamps it to MAX_ELEMS.
- Dead set (all zero) mid-string: stay in RUN and keep consuming until last; result=0.
- Config writes:
  - Accepted only in IDLE/DONE. Ignored while busy=1, so the pattern is stable for a whole string.
  - cfg_we and cfg_len_we may be active in the same cycle; both take effect.
  - A config write in the same cycle as a start symbol is applied before evaluation, and that symbol uses the new pattern.
- match_count increments at the DONE transition when result=1. It saturates at all-ones.
- res_n asserted mid-string: immediate return to reset values, including the pattern. Software must reprogram after reset.

Decomposition:
- Package regex_pkg holds:
  - State encoding localparams S_IDLE, S_RUN, S_DONE.
  - Symbol constants SYM_A..SYM_D for SYM_W=2.
  - Element record layout {rep, sym}.
- One sub-module, regex_nfa_stage: one element's comparator plus active bit. It has a generate loop over MAX_ELEMS and a shared consume/start control.

Test Plan:
- Program AB+CA+BD (len 6: A,B+,C,A+,B,D). Run ABBBCAABD with last on D:
  - result=1, done=1 after the last edge, match_count=1.
- Same pattern, strings ABCDD, ABCDDD, ABBCAAD fed back-to-back with no reset:
  - each string gives done=1, result=0; match_count stays 1.
  - done deasserts on each new first symbol.
- ABBBCAABD with symbol_valid dropped for 3 cycles after the 4th symbol:
  - result=1, same as without the gaps.
- cfg_we writing element 0 = D while busy=1 (mid-string):
  - ignored; the string still matches.
  - After DONE, the write is accepted, and the next ABBBCAABD gives result=0.
- res_n pulsed low mid-string:
  - done=0, result=0, match_count=0, len=0 immediately.
  - A following one-symbol string "A" with last gives done=1, result=0.
- Set len=1, element 0 = A+. Run AAAA (last on 4th A): result=1. Then run single A: result=1.
  - Force match_count to saturate at 255 with CNT_W=8; it stays 255.

Source files
------------

// File: rtl/regex_pkg.sv
// Shared types and constants for the programmable sequence-regex matcher.
// Holds the FSM state encoding, the symbol alphabet and the per-element
// pattern record {rep, sym}.
package regex_pkg;

   // Symbol width; the alphabet A..D maps onto 2-bit codes.
   localparam int unsigned SYM_W = 2;

   localparam logic [SYM_W-1:0] SYM_A = SYM_W'(0);
   localparam logic [SYM_W-1:0] SYM_B = SYM_W'(1);
   localparam logic [SYM_W-1:0] SYM_C = SYM_W'(2);
   localparam logic [SYM_W-1:0] SYM_D = SYM_W'(3);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   // One pattern element: literal symbol plus one-or-more flag.
   typedef struct packed {
      logic             rep;
      logic [SYM_W-1:0] sym;
   } elem_t;

   localparam elem_t ELEM_RESET = '{rep: 1'b0, sym: SYM_A};

endpackage

// File: rtl/regex_prog_matcher_if.sv
// Bus bundle for regex_prog_matcher.
//   master: drives pattern config (cfg_*) and the symbol stream
//           (symbol_valid, symbol_in, last_symbol); observes status.
//   slave : the matcher; drives busy, result, done, match_count.
interface regex_prog_matcher_if #(
   parameter int unsigned MAX_ELEMS = 8,
   parameter int unsigned CNT_W     = 8
);
   import regex_pkg::*;

   localparam int unsigned ADDR_W = $clog2(MAX_ELEMS);
   localparam int unsigned LEN_W  = $clog2(MAX_ELEMS + 1);

   logic              cfg_we;
   logic [ADDR_W-1:0] cfg_addr;
   logic [SYM_W-1:0]  cfg_sym;
   logic              cfg_rep;
   logic              cfg_len_we;
   logic [LEN_W-1:0]  cfg_len;
   logic              symbol_valid;
   logic [SYM_W-1:0]  symbol_in;
   logic              last_symbol;
   logic              busy;
   logic              result;
   logic              done;
   logic [CNT_W-1:0]  match_count;

   modport master (
      output cfg_we, cfg_addr, cfg_sym, cfg_rep, cfg_len_we, cfg_len,
      output symbol_valid, symbol_in, last_symbol,
      input  busy, result, done, match_count
   );

   modport slave (
      input  cfg_we, cfg_addr, cfg_sym, cfg_rep, cfg_len_we, cfg_len,
      input  symbol_valid, symbol_in, last_symbol,
      output busy, result, done, match_count
   );

endinterface

// File: rtl/regex_nfa_stage.sv
// One NFA element: symbol comparator plus the active bit that means
// "the pattern prefix ending at this element has matched so far".
// Ports:
//   clk, res_n     clock, async active-low reset
//   consume_i      a symbol is consumed this edge
//   en_i           element lies inside the active pattern length
//   prev_act_i     active bit feeding this element (start bit for element 0)
//   self_act_i     this element's own active bit, cleared at string start
//   elem_i         element record {rep, sym}
//   symbol_i       current input symbol
//   act_o          registered active bit
//   nxt_c          next active bit for the symbol being consumed
module regex_nfa_stage
   import regex_pkg::*;
(
   input  logic             clk,
   input  logic             res_n,
   input  logic             consume_i,
   input  logic             en_i,
   input  logic             prev_act_i,
   input  logic             self_act_i,
   input  elem_t            elem_i,
   input  logic [SYM_W-1:0] symbol_i,
   output logic             act_o,
   output logic             nxt_c
);

   logic act_q;
   logic hit_c;

   // Advance from the previous element, or stay here on a repeat.
   always_comb begin
      hit_c = (elem_i.sym == symbol_i);
      nxt_c = en_i & hit_c & (prev_act_i | (self_act_i & elem_i.rep));
   end

   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         act_q <= 1'b0;
      end else if (consume_i) begin
         act_q <= nxt_c;
      end
   end

   assign act_o = act_q;

endmodule

// File: rtl/regex_prog_matcher.sv
// Programmable anchored sequence-regex matcher.
// Pattern is up to MAX_ELEMS literal elements, each optionally "+".
// Strings arrive as a valid-qualified symbol stream with a last marker;
// each completed string reports done/result and bumps a saturating count.
// Ports:
//   clk, res_n   clock, async active-low reset (also clears the pattern)
//   bus (slave)  config writes, symbol stream, busy/result/done/match_count
module regex_prog_matcher
   import regex_pkg::*;
#(
   parameter int unsigned MAX_ELEMS = 8,
   parameter int unsigned CNT_W     = 8
) (
   input  logic                 clk,
   input  logic                 res_n,
   regex_prog_matcher_if.slave  bus
);

   localparam int unsigned LEN_W = $clog2(MAX_ELEMS + 1);

   state_e            state_q, state_d;
   elem_t             elem_q [MAX_ELEMS];
   elem_t             elem_d [MAX_ELEMS];
   logic [LEN_W-1:0]  len_q, len_d;
   logic              busy_q, busy_d;
   logic              result_q, result_d;
   logic              done_q, done_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic              cfg_ok_c;
   logic              start_c;
   logic              match_c;
   logic [MAX_ELEMS-1:0] act_w;
   logic [MAX_ELEMS-1:0] prev_w;
   logic [MAX_ELEMS-1:0] self_w;
   logic [MAX_ELEMS:0]   nxt_w;

   // Pattern updates; applied combinationally so a start symbol in the
   // same cycle already sees the new pattern.
   always_comb begin
      cfg_ok_c = (state_q != S_RUN);
      elem_d   = elem_q;
      len_d    = len_q;
      if (cfg_ok_c && bus.cfg_we && (32'(bus.cfg_addr) < MAX_ELEMS)) begin
         elem_d[bus.cfg_addr] = '{rep: bus.cfg_rep, sym: bus.cfg_sym};
      end
      if (cfg_ok_c && bus.cfg_len_we) begin
         if (32'(bus.cfg_len) > MAX_ELEMS) begin
            len_d = LEN_W'(MAX_ELEMS);
         end else begin
            len_d = bus.cfg_len;
         end
      end
   end

   assign start_c  = bus.symbol_valid && (state_q != S_RUN);
   assign nxt_w[0] = 1'b0;

   // Element chain; element 0 is seeded only by the first symbol of a string.
   for (genvar i = 0; i < MAX_ELEMS; i++) begin : g_stage
      if (i == 0) begin : g_first
         assign prev_w[i] = start_c;
      end else begin : g_rest
         assign prev_w[i] = act_w[i-1] & ~start_c;
      end
      assign self_w[i] = act_w[i] & ~start_c;

      regex_nfa_stage u_stage (
         .clk        (clk),
         .res_n      (res_n),
         .consume_i  (bus.symbol_valid),
         .en_i       (LEN_W'(i) < len_d),
         .prev_act_i (prev_w[i]),
         .self_act_i (self_w[i]),
         .elem_i     (elem_d[i]),
         .symbol_i   (bus.symbol_in),
         .act_o      (act_w[i]),
         .nxt_c      (nxt_w[i+1])
      );
   end

   // Anchored match: final element reached by the last symbol; len 0 never matches.
   assign match_c = nxt_w[len_d];

   // Next-state and status outputs.
   always_comb begin
      state_d  = state_q;
      done_d   = done_q;
      result_d = result_q;
      cnt_d    = cnt_q;
      if (bus.symbol_valid) begin
         if (bus.last_symbol) begin
            state_d  = S_DONE;
            done_d   = 1'b1;
            result_d = match_c;
            if (match_c && (cnt_q != '1)) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end else if (state_q != S_RUN) begin
            state_d  = S_RUN;
            done_d   = 1'b0;
            result_d = 1'b0;
         end
      end
      busy_d = (state_d == S_RUN);
   end

   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         state_q  <= S_IDLE;
         len_q    <= '0;
         busy_q   <= 1'b0;
         result_q <= 1'b0;
         done_q   <= 1'b0;
         cnt_q    <= '0;
         for (int i = 0; i < MAX_ELEMS; i++) begin
            elem_q[i] <= ELEM_RESET;
         end
      end else begin
         state_q  <= state_d;
         len_q    <= len_d;
         busy_q   <= busy_d;
         result_q <= result_d;
         done_q   <= done_d;
         cnt_q    <= cnt_d;
         elem_q   <= elem_d;
      end
   end

   assign bus.busy        = busy_q;
   assign bus.result      = result_q;
   assign bus.done        = done_q;
   assign bus.match_count = cnt_q;

endmodule

// File: tb/tb_regex_prog_matcher.sv
// Self-checking bench for regex_prog_matcher: directed scenarios plus
// randomized patterns/strings checked against a segmentation model.
module tb_regex_prog_matcher;

   localparam int unsigned MAX_ELEMS = 8;
   localparam int unsigned CNT_W     = 8;
   localparam int A = 0, B = 1, C = 2, D = 3;

   logic clk;
   logic res_n;

   regex_prog_matcher_if #(.MAX_ELEMS(MAX_ELEMS), .CNT_W(CNT_W)) bus ();

   regex_prog_matcher #(.MAX_ELEMS(MAX_ELEMS), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .res_n (res_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference pattern and expected status.
   int pat_sym [MAX_ELEMS];
   bit pat_rep [MAX_ELEMS];
   int pat_len   = 0;
   int exp_cnt   = 0;
   bit in_string = 0;

   // String matches iff it splits into pat_len consecutive non-empty runs,
   // run k made only of pat_sym[k], of length exactly 1 unless pat_rep[k].
   function automatic bit model_match(input int s[$]);
      bit ok [0:MAX_ELEMS][0:64];
      int n;
      int maxr;
      bit run_ok;
      n = s.size();
      if (pat_len == 0 || n > 64 || n == 0) return 1'b0;
      for (int k = 0; k <= MAX_ELEMS; k++)
         for (int j = 0; j <= 64; j++) ok[k][j] = 1'b0;
      ok[0][0] = 1'b1;
      for (int k = 1; k <= pat_len; k++) begin
         for (int j = 1; j <= n; j++) begin
            maxr   = pat_rep[k-1] ? j : 1;
            run_ok = 1'b1;
            for (int r = 1; r <= maxr; r++) begin
               run_ok = run_ok && (s[j-r] == pat_sym[k-1]);
               if (!run_ok) break;
               if (ok[k-1][j-r]) ok[k][j] = 1'b1;
            end
         end
      end
      return ok[pat_len][n];
   endfunction

   task automatic cycle();
      @(posedge clk); #1;
   endtask

   task automatic model_clear();
      for (int i = 0; i < MAX_ELEMS; i++) begin
         pat_sym[i] = 0;
         pat_rep[i] = 1'b0;
      end
      pat_len   = 0;
      exp_cnt   = 0;
      in_string = 1'b0;
   endtask

   task automatic send_sym(input int s, input bit last);
      bus.symbol_valid = 1'b1;
      bus.symbol_in    = 2'(s);
      bus.last_symbol  = last;
      cycle();
      bus.symbol_valid = 1'b0;
      bus.last_symbol  = 1'b0;
      in_string        = !last;
   endtask

   task automatic cfg_elem(input int a, input int s, input bit r);
      bus.cfg_we   = 1'b1;
      bus.cfg_addr = 3'(a);
      bus.cfg_sym  = 2'(s);
      bus.cfg_rep  = r;
      cycle();
      bus.cfg_we = 1'b0;
      if (!in_string) begin
         pat_sym[a] = s;
         pat_rep[a] = r;
      end
   endtask

   task automatic cfg_length(input int l);
      bus.cfg_len_we = 1'b1;
      bus.cfg_len    = 4'(l);
      cycle();
      bus.cfg_len_we = 1'b0;
      if (!in_string) pat_len = (l > MAX_ELEMS) ? MAX_ELEMS : l;
   endtask

   task automatic program_main();
      int ps [6] = '{A, B, C, A, B, D};
      bit pr [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 6; i++) cfg_elem(i, ps[i], pr[i]);
      cfg_length(6);
   endtask

   // Feed one string; optional idle gap before symbol gap_after and an
   // element-0 config write attempt before symbol inj_at.
   task automatic run_string(input string tag, input int s[$], input int gap_after,
                             input int gap_len, input int inj_at, input int inj_sym);
      int n;
      bit er;
      n = s.size();
      for (int k = 0; k < n; k++) begin
         if (k == inj_at) cfg_elem(0, inj_sym, 1'b0);
         if (k == gap_after && k > 0) begin
            for (int g = 0; g < gap_len; g++) begin
               cycle();
               n_checks++;
               if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
                  n_fail++;
                  $display("FAIL %s stall: busy=%0b done=%0b expected busy=1 done=0",
                           tag, bus.busy, bus.done);
               end
            end
         end
         send_sym(s[k], k == n - 1);
         if (k == 0 && n > 1) begin
            n_checks++;
            if (bus.done !== 1'b0 || bus.result !== 1'b0 || bus.busy !== 1'b1) begin
               n_fail++;
               $display("FAIL %s start: done=%0b result=%0b busy=%0b expected 0 0 1",
                        tag, bus.done, bus.result, bus.busy);
            end
         end
      end
      er = model_match(s);
      if (er && exp_cnt < 255) exp_cnt++;
      n_checks++;
      if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL %s end: done=%0b busy=%0b expected done=1 busy=0", tag, bus.done, bus.busy);
      end
      n_checks++;
      if (bus.result !== er) begin
         n_fail++;
         $display("FAIL %s result: got %0b expected %0b", tag, bus.result, er);
      end
      n_checks++;
      if (bus.match_count !== 8'(exp_cnt)) begin
         n_fail++;
         $display("FAIL %s count: got %0d expected %0d", tag, bus.match_count, exp_cnt);
      end
   endtask

   task automatic test_reset();
      res_n            = 1'b0;
      bus.cfg_we       = 1'b0;
      bus.cfg_addr     = '0;
      bus.cfg_sym      = '0;
      bus.cfg_rep      = 1'b0;
      bus.cfg_len_we   = 1'b0;
      bus.cfg_len      = '0;
      bus.symbol_valid = 1'b0;
      bus.symbol_in    = '0;
      bus.last_symbol  = 1'b0;
      model_clear();
      cycle();
      cycle();
      n_checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 1'b0 || bus.match_count !== 8'd0) begin
         n_fail++;
         $display("FAIL reset: busy=%0b done=%0b result=%0b count=%0d expected all 0",
                  bus.busy, bus.done, bus.result, bus.match_count);
      end
      res_n = 1'b1;
      cycle();
      // Length 0 after reset: any string fails.
      run_string("len0", '{A}, -1, 0, -1, 0);
   endtask

   task automatic test_basic();
      program_main();
      run_string("basic", '{A, B, B, B, C, A, A, B, D}, -1, 0, -1, 0);
   endtask

   task automatic test_back_to_back();
      run_string("b2b_1", '{A, B, C, D, D}, -1, 0, -1, 0);
      run_string("b2b_2", '{A, B, C, D, D, D}, -1, 0, -1, 0);
      run_string("b2b_3", '{A, B, B, C, A, A, D}, -1, 0, -1, 0);
   endtask

   task automatic test_stall();
      run_string("stall", '{A, B, B, B, C, A, A, B, D}, 4, 3, -1, 0);
   endtask

   task automatic test_cfg_busy();
      run_string("cfg_busy", '{A, B, B, B, C, A, A, B, D}, -1, 0, 3, D);
      run_string("cfg_after", '{A, B, B, B, C, A, A, B, D}, -1, 0, 0, D);
   endtask

   task automatic test_res_mid();
      send_sym(A, 1'b0);
      send_sym(B, 1'b0);
      res_n = 1'b0;
      #1;
      model_clear();
      n_checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 1'b0 || bus.match_count !== 8'd0) begin
         n_fail++;
         $display("FAIL res_mid: busy=%0b done=%0b result=%0b count=%0d expected all 0",
                  bus.busy, bus.done, bus.result, bus.match_count);
      end
      cycle();
      res_n = 1'b1;
      cycle();
      run_string("res_mid_A", '{A}, -1, 0, -1, 0);
   endtask

   task automatic test_cfg_same_cycle();
      cfg_elem(0, A, 1'b0);
      cfg_length(1);
      // Element rewrite and one-symbol string in the same cycle.
      bus.cfg_we       = 1'b1;
      bus.cfg_addr     = 3'd0;
      bus.cfg_sym      = 2'(B);
      bus.cfg_rep      = 1'b0;
      pat_sym[0]       = B;
      send_sym(B, 1'b1);
      bus.cfg_we = 1'b0;
      exp_cnt++;
      n_checks++;
      if (bus.done !== 1'b1 || bus.result !== 1'b1 || bus.match_count !== 8'(exp_cnt)) begin
         n_fail++;
         $display("FAIL same_cycle: done=%0b result=%0b count=%0d expected 1 1 %0d",
                  bus.done, bus.result, bus.match_count, exp_cnt);
      end
      run_string("same_cycle_A", '{A}, -1, 0, -1, 0);
   endtask

   task automatic test_random();
      int s[$];
      int n;
      for (int it = 0; it < 40; it++) begin
         for (int i = 0; i < MAX_ELEMS; i++) cfg_elem(i, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
         cfg_length(int'($urandom_range(0, 12)));
         s.delete();
         if ($urandom_range(0, 1) == 1 && pat_len > 0) begin
            for (int k = 0; k < pat_len; k++) begin
               n = pat_rep[k] ? int'($urandom_range(1, 3)) : 1;
               for (int r = 0; r < n; r++) s.push_back(pat_sym[k]);
            end
            if ($urandom_range(0, 3) == 0) s[$urandom_range(0, s.size() - 1)] = int'($urandom_range(0, 3));
         end else begin
            n = int'($urandom_range(1, 12));
            for (int k = 0; k < n; k++) s.push_back(int'($urandom_range(0, 3)));
         end
         n = s.size();
         run_string("random", s, (n > 1) ? int'($urandom_range(1, n - 1)) : -1,
                    int'($urandom_range(0, 2)), -1, 0);
      end
   endtask

   task automatic test_plus_sat();
      cfg_elem(0, A, 1'b1);
      cfg_length(1);
      run_string("plus_AAAA", '{A, A, A, A}, -1, 0, -1, 0);
      run_string("plus_A", '{A}, -1, 0, -1, 0);
      while (exp_cnt < 255) run_string("sat_fill", '{A}, -1, 0, -1, 0);
      run_string("sat_1", '{A}, -1, 0, -1, 0);
      run_string("sat_2", '{A, A}, -1, 0, -1, 0);
      n_checks++;
      if (bus.match_count !== 8'd255) begin
         n_fail++;
         $display("FAIL saturate: got %0d expected 255", bus.match_count);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_stall();
      test_cfg_busy();
      test_res_mid();
      test_cfg_same_cycle();
      test_random();
      test_plus_sat();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
